// File: rtl/ex_result_buffer.sv
// Execute-stage result buffer: 2-entry skid buffer between the ALU and writeback.
// Optional operand-bypass outputs (fwd_*) are enabled by defining EX_FWD_EN.
module ex_result_buffer #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef EX_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t r_state, w_state_next;
  logic   r_in_ready;

  logic [DATA_W-1:0] r_main_result, r_skid_result;
  logic              r_main_zero,   r_skid_zero;
  logic [RD_W-1:0]   r_main_rd,     r_skid_rd;
  logic              r_main_we,     r_skid_we;

  logic w_accept, w_pop, w_main_valid, w_skid_valid, w_in_we;
  logic w_load_main_in, w_load_main_skid, w_load_skid_in;

  assign w_main_valid = (r_state != EMPTY);
  assign w_skid_valid = (r_state == FULL);
  assign w_accept     = in_valid & r_in_ready;
  assign w_pop        = w_main_valid & out_ready;
  assign w_in_we      = in_reg_write & (in_rd != '0);

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    case (r_state)
      EMPTY: if (w_accept) begin
        w_state_next   = ONE;
        w_load_main_in = 1'b1;
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_next   = FULL;
          w_load_skid_in = 1'b1;
        end else if (w_pop) begin
          w_state_next   = EMPTY;
        end
      end
      FULL: if (w_pop) begin
        w_state_next     = ONE;
        w_load_main_skid = 1'b1;
      end
      default: w_state_next = EMPTY;
    endcase
    // Flush wins over everything; suppressing loads keeps data registers untouched.
    if (flush) begin
      w_state_next     = EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_result <= '0;
      r_main_zero   <= 1'b0;
      r_main_rd     <= '0;
      r_main_we     <= 1'b0;
      r_skid_result <= '0;
      r_skid_zero   <= 1'b0;
      r_skid_rd     <= '0;
      r_skid_we     <= 1'b0;
    end else begin
      if (w_load_main_in) begin
        r_main_result <= in_result;
        r_main_zero   <= in_zero;
        r_main_rd     <= in_rd;
        r_main_we     <= w_in_we;
      end else if (w_load_main_skid) begin
        r_main_result <= r_skid_result;
        r_main_zero   <= r_skid_zero;
        r_main_rd     <= r_skid_rd;
        r_main_we     <= r_skid_we;
      end
      if (w_load_skid_in) begin
        r_skid_result <= in_result;
        r_skid_zero   <= in_zero;
        r_skid_rd     <= in_rd;
        r_skid_we     <= w_in_we;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = w_main_valid;
  assign out_result    = r_main_result;
  assign out_zero      = r_main_zero;
  assign out_rd        = r_main_rd;
  assign out_reg_write = r_main_we;
  assign occupancy     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`ifdef EX_FWD_EN
  logic w_fwd_skid, w_fwd_main;

  // Skid is the younger entry, so it wins when both are writing.
  assign w_fwd_skid = w_skid_valid & r_skid_we;
  assign w_fwd_main = w_main_valid & r_main_we;

  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (w_fwd_skid) begin
      fwd_valid = 1'b1;
      fwd_rd    = r_skid_rd;
      fwd_data  = r_skid_result;
    end else if (w_fwd_main) begin
      fwd_valid = 1'b1;
      fwd_rd    = r_main_rd;
      fwd_data  = r_main_result;
    end
  end
`endif

endmodule

// File: tb/tb_ex_result_buffer.sv
// Self-checking bench for ex_result_buffer: vector table plus a scoreboard
// monitor that predicts occupancy/handshake and checks every popped beat.
module tb_ex_result_buffer;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic [RD_W-1:0]   in_rd;
  logic              in_reg_write;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic [RD_W-1:0]   out_rd;
  logic              out_reg_write;
  logic              flush;
  logic [1:0]        occupancy;
`ifdef EX_FWD_EN
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif

  ex_result_buffer #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .flush(flush), .occupancy(occupancy)
`ifdef EX_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [RD_W-1:0]   rd;
    logic              we;
  } beat_t;

  typedef struct {
    logic              v;
    logic              ordy;
    logic              fl;
    logic [DATA_W-1:0] res;
    logic              z;
    logic [RD_W-1:0]   rd;
    logic              we;
    int                exp_occ;
  } vec_t;

  int errors = 0;
  int checks = 0;
  beat_t q[$];
  int m_occ = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every negedge sees the inputs that the next posedge will sample.
  task automatic monitor_loop();
    beat_t e, n;
    logic acc, pop;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_occ = 0;
      end else begin
        check("occupancy", 64'(occupancy), 64'(m_occ));
        check("in_ready", 64'(in_ready), 64'(m_occ < 2));
        check("out_valid", 64'(out_valid), 64'(m_occ > 0));
        acc = in_valid && (m_occ < 2);
        pop = (m_occ > 0) && out_ready;
        if (pop && q.size() > 0) begin
          e = q.pop_front();
          check("out_result", 64'(out_result), 64'(e.result));
          check("out_zero", 64'(out_zero), 64'(e.zero));
          check("out_rd", 64'(out_rd), 64'(e.rd));
          check("out_reg_write", 64'(out_reg_write), 64'(e.we));
        end
        if (flush) begin
          q.delete();
        end else if (acc) begin
          n.result = in_result;
          n.zero   = in_zero;
          n.rd     = in_rd;
          n.we     = in_reg_write && (in_rd != 0);
          q.push_back(n);
        end
        m_occ = q.size();
      end
    end
  endtask

  function automatic vec_t mk(input logic v, input logic ordy, input logic fl,
                              input logic [DATA_W-1:0] res, input logic z,
                              input logic [RD_W-1:0] rd, input logic we, input int occ);
    vec_t t;
    t.v = v; t.ordy = ordy; t.fl = fl; t.res = res; t.z = z;
    t.rd = rd; t.we = we; t.exp_occ = occ;
    return t;
  endfunction

  task automatic drive(input logic v, input logic ordy, input logic fl,
                       input logic [DATA_W-1:0] res, input logic z,
                       input logic [RD_W-1:0] rd, input logic we);
    in_valid = v; out_ready = ordy; flush = fl;
    in_result = res; in_zero = z; in_rd = rd; in_reg_write = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];

  initial begin
    fork
      begin #200000; $display("FAIL timeout: simulation exceeded time budget"); $fatal(1); end
    join_none
    fork monitor_loop(); join_none

    vecs[0]  = mk(1, 1, 0, 32'h1,  0, 5'd1,  1, 1);
    vecs[1]  = mk(1, 1, 0, 32'h2,  1, 5'd2,  1, 1);
    vecs[2]  = mk(1, 1, 0, 32'h3,  0, 5'd3,  0, 1);
    vecs[3]  = mk(0, 1, 0, 32'h0,  0, 5'd0,  0, 0);
    vecs[4]  = mk(1, 0, 0, 32'hA,  0, 5'd5,  1, 1);
    vecs[5]  = mk(1, 0, 0, 32'hB,  1, 5'd6,  1, 2);
    vecs[6]  = mk(1, 0, 0, 32'hC,  0, 5'd7,  1, 2);
    vecs[7]  = mk(1, 1, 0, 32'hC,  0, 5'd7,  1, 1);
    vecs[8]  = mk(1, 1, 0, 32'hC,  0, 5'd7,  1, 1);
    vecs[9]  = mk(0, 1, 0, 32'h0,  0, 5'd0,  0, 0);
    vecs[10] = mk(1, 0, 0, 32'h55, 1, 5'd0,  1, 1);
    vecs[11] = mk(0, 1, 0, 32'h0,  0, 5'd0,  0, 0);
    vecs[12] = mk(1, 0, 0, 32'h11, 0, 5'd8,  1, 1);
    vecs[13] = mk(1, 0, 0, 32'h22, 0, 5'd9,  1, 2);
    vecs[14] = mk(1, 0, 1, 32'h33, 0, 5'd10, 1, 0);
    vecs[15] = mk(0, 1, 0, 32'h0,  0, 5'd0,  0, 0);
    vecs[16] = mk(1, 0, 0, 32'h44, 1, 5'd10, 1, 1);
    vecs[17] = mk(1, 1, 1, 32'h66, 0, 5'd12, 1, 0);
    vecs[18] = mk(1, 1, 0, 32'h77, 0, 5'd11, 0, 1);
    vecs[19] = mk(0, 1, 0, 32'h0,  0, 5'd0,  0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, '0, 0, '0, 0);
    step(); step();
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_occupancy", 64'(occupancy), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_fields", {31'd0, out_result, out_zero}, 64'(0));
    check("reset_out_rd_we", 64'({out_rd, out_reg_write}), 64'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].ordy, vecs[i].fl, vecs[i].res, vecs[i].z, vecs[i].rd, vecs[i].we);
      step();
      check($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_occ != 2));
    end
    drive(0, 0, 0, '0, 0, '0, 0);
    // Last load was 0x77 (the flush-cycle beat 0x66 never landed); data persists after the pop.
    check("hold_after_pop", 64'(out_result), 64'(32'h77));

    // Async reset in the middle of a cycle while FULL.
    drive(1, 0, 0, 32'hDEAD, 1, 5'd13, 1); step();
    drive(1, 0, 0, 32'hBEEF, 0, 5'd14, 1); step();
    check("pre_reset_occ", 64'(occupancy), 64'(2));
    drive(0, 0, 0, '0, 0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'(0));
    check("async_occupancy", 64'(occupancy), 64'(0));
    check("async_in_ready", 64'(in_ready), 64'(1));
    check("async_out_result", 64'(out_result), 64'(0));
    check("async_out_rd_we", 64'({out_rd, out_reg_write, out_zero}), 64'(0));
    step();
    rst_n = 1'b1;
    drive(1, 0, 0, 32'h99, 0, 5'd15, 1); step();
    drive(0, 1, 0, '0, 0, '0, 0);
    check("post_reset_latency", 64'({out_valid, out_result}), {31'd0, 1'b1, 32'h99});
    step(); step();

`ifdef EX_FWD_EN
    check("fwd_idle", 64'(fwd_valid), 64'(0));
    drive(1, 0, 0, 32'h10, 0, 5'd3, 1); step();
    drive(1, 0, 0, 32'h20, 0, 5'd4, 1); step();
    drive(0, 0, 0, '0, 0, '0, 0);
    check("fwd_full_valid", 64'(fwd_valid), 64'(1));
    check("fwd_full_rd", 64'(fwd_rd), 64'(4));
    check("fwd_full_data", 64'(fwd_data), 64'(32'h20));
    drive(0, 1, 0, '0, 0, '0, 0); step();
    drive(0, 0, 0, '0, 0, '0, 0);
    check("fwd_pop1_rd", 64'(fwd_rd), 64'(4));
    check("fwd_pop1_valid", 64'(fwd_valid), 64'(1));
    drive(0, 1, 0, '0, 0, '0, 0); step();
    drive(0, 0, 0, '0, 0, '0, 0);
    check("fwd_pop2_valid", 64'(fwd_valid), 64'(0));
    drive(1, 0, 0, 32'h30, 0, 5'd6, 1); step();
    drive(1, 0, 1, 32'h40, 0, 5'd7, 1); step();
    drive(0, 0, 0, '0, 0, '0, 0);
    check("fwd_flush_valid", 64'(fwd_valid), 64'(0));
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_result_buffer.md
Name: ex_result_buffer

Overview:
Execute-stage output buffer directly downstream of the ALU: captures the ALU result, zero flag and destination-register tag into a 2-entry skid buffer. Presents the captured result to the writeback stage under a valid/ready handshake. Isolates the combinational ALU from writeback back-pressure with one cycle of latency and full throughput. Supports a pipeline flush for branch redirects.

Parameters:
DATA_W, 32, width of ALU result and buffered data
RD_W, 5, width of destination register index

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute stage presents a result this cycle
in_ready  out  1  buffer can accept a result this cycle
in_result  in  DATA_W  ALU result
in_zero  in  1  ALU zero flag
in_rd  in  RD_W  destination register index
in_reg_write  in  1  result is to be written to the register file
out_valid  out  1  head entry valid toward writeback
out_ready  in  1  writeback consumes head entry this cycle
out_result  out  DATA_W  head entry result
out_zero  out  1  head entry zero flag
out_rd  out  RD_W  head entry rd
out_reg_write  out  1  head entry write enable
flush  in  1  synchronous discard of all buffered and incoming entries
occupancy  out  2  number of valid entries (0..2)

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each entry holds result, zero, rd, reg_write and a valid bit.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~skid_valid, driven from a register. No combinational path from out_ready to in_ready.
- out_valid = main_valid. out_* are driven directly from main-entry registers.
- States: EMPTY (occupancy 0), ONE (1), FULL (2).
- EMPTY: accept -> ONE, incoming loaded to main. Otherwise stay.
- ONE: accept & pop -> ONE, main <- incoming. Accept only -> FULL, skid <- incoming. Pop only -> EMPTY. Neither -> stay.
- FULL: in_ready=0, so no accept. Pop -> ONE, main <- skid. No pop -> stay, all fields held.
- Latency: a result accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY, or when it was ONE with a pop.
- Throughput: one result per cycle while out_ready=1. Ordering is strictly FIFO.
- Capture rule: if in_rd == 0, the stored reg_write is forced to 0. Result and zero are stored unchanged. No arithmetic is performed on data.
- Data fields of an entry update only when that entry is loaded. They are held otherwise, including after a pop.
- flush: takes priority over accept and pop. Next cycle main_valid = skid_valid = 0 and the state is EMPTY. A beat accepted in the flush cycle is discarded. A pop in the flush cycle is still consumed by writeback. Data registers are not cleared.
- Reset (rst_n=0, async): the state becomes EMPTY and all valid bits clear. out_valid=0, out_result=0, out_zero=0, out_rd=0, out_reg_write=0, occupancy=0, in_ready=1. Reset asserted mid-transfer discards all entries. The first accept after deassertion behaves as from EMPTY.
- occupancy = main_valid + skid_valid. It never exceeds 2, and skid_valid=1 implies main_valid=1.

Optional Feature:
Macro EX_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (RD_W) and fwd_data (DATA_W) for the ALU operand-bypass mux.
- The outputs expose the youngest valid entry with reg_write=1: skid if valid and writing, else main. fwd_valid=0 when no such entry exists, after flush, and in reset. fwd_rd/fwd_data reset to 0.
- Not defined: the ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> out_valid=0, occupancy=0, in_ready=1 immediately (async); all out_* = 0.
- Streaming: out_ready=1, results 0x1, 0x2, 0x3 on consecutive cycles -> the same values appear on out_result one cycle later, back-to-back; occupancy stays 1.
- Back-pressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, and 0xC is held off. Raise out_ready -> 0xA, 0xB, 0xC drain in order.
- rd zero: in_rd=0, in_reg_write=1, in_result=0x55 -> out_reg_write=0, out_result=0x55, out_rd=0.
- Flush when FULL: occupancy=2 with in_valid=1, assert flush for 1 cycle -> next cycle out_valid=0, occupancy=0, in_ready=1, and the incoming beat is not output.
- EX_FWD_EN: main holds rd=3/0x10 and skid holds rd=4/0x20 with reg_write=1 -> fwd_rd=4, fwd_data=0x20. Pop -> fwd_rd=4. Pop again -> fwd_valid=0.
